// File: rtl/time_pkg.sv
// Shared types, limits and MM:SS step helpers for the stopwatch/timer datapath.
// Pure declarations: no state, no latency, no flow control.
package time_pkg;

    typedef struct packed {
        logic [6:0] min;
        logic [5:0] sec;
    } time_t;

    localparam logic [6:0] MAX_MIN   = 7'd99;
    localparam logic [5:0] MAX_SEC   = 6'd59;
    localparam logic [1:0] SEL_LAP   = 2'b10;
    localparam time_t      TIME_ZERO = '0;

    // One second forward; 99:59 is a hard ceiling rather than a wrap point.
    function automatic time_t time_up(input time_t t);
        time_t r;
        r = t;
        if (t.sec != MAX_SEC) begin
            r.sec = t.sec + 6'd1;
        end else if (t.min != MAX_MIN) begin
            r.min = t.min + 7'd1;
            r.sec = 6'd0;
        end
        return r;
    endfunction

    // One second back; 00:00 is a hard floor.
    function automatic time_t time_down(input time_t t);
        time_t r;
        r = t;
        if (t.sec != 6'd0) begin
            r.sec = t.sec - 6'd1;
        end else if (t.min != 7'd0) begin
            r.min = t.min - 7'd1;
            r.sec = MAX_SEC;
        end
        return r;
    endfunction

    function automatic time_t time_inc_min(input time_t t);
        time_t r;
        r = t;
        if (t.min != MAX_MIN) begin
            r.min = t.min + 7'd1;
        end
        return r;
    endfunction

    function automatic logic time_is_zero(input time_t t);
        return (t.min == 7'd0) && (t.sec == 6'd0);
    endfunction

endpackage

// File: rtl/time_datapath_tick_gen.sv
// Second-tick prescaler: one-cycle tick when the count reaches TICKS_PER_SEC-1.
// First tick lands TICKS_PER_SEC cycles after run rises; no backpressure, held at 0 when idle.
module tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 10_000_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && !sync_clr && (cnt_q == LAST);

    // Stopping resets the phase so every restart waits a full second.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_datapath.sv
// Live MM:SS register, second prescaler and circular lap memory with display mux.
// Updates land one cycle after the strobe; flag and display are combinational; no backpressure.
module time_datapath
    import time_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10_000_000,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clear,
    input  logic                         enable,
    input  logic                         enable_decrement,
    input  logic                         enable_increment,
    input  logic                         inc_pulse,
    input  logic                         write,
    input  logic                         read,
    input  logic [1:0]                   output_select,
    output logic                         flag,
    output logic [6:0]                   disp_min,
    output logic [5:0]                   disp_sec,
    output logic [$clog2(DEPTH+1)-1:0]   lap_count
);

    localparam int unsigned    PW   = $clog2(DEPTH);
    localparam int unsigned    LCW  = $clog2(DEPTH + 1);
    localparam logic [LCW-1:0] FULL = LCW'(DEPTH);

    time_t          time_q;
    time_t          time_d;
    time_t          lap_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  rd_ptr_d;
    logic [LCW-1:0] lap_cnt_q;
    logic [LCW-1:0] lap_cnt_d;
    logic [PW-1:0]  oldest;
    logic           tick;
    time_t          disp_time;

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk      (clk),
        .nrst     (nrst),
        .run      (enable || enable_decrement),
        .sync_clr (clear),
        .tick     (tick)
    );

    // Countdown outranks count-up should the controller ever raise both.
    always_comb begin
        time_d = time_q;
        if (clear) begin
            time_d = TIME_ZERO;
        end else if (inc_pulse && enable_increment) begin
            time_d = time_inc_min(time_q);
        end else if (tick && enable_decrement) begin
            time_d = time_down(time_q);
        end else if (tick && enable) begin
            time_d = time_up(time_q);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            time_q <= TIME_ZERO;
        end else begin
            time_q <= time_d;
        end
    end

    assign oldest = (lap_cnt_q == FULL) ? wr_ptr_q : '0;

    // Read walks newest-to-oldest and wraps back to the newest entry.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lap_cnt_d = lap_cnt_q;
        if (write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = wr_ptr_q;
            if (lap_cnt_q != FULL) begin
                lap_cnt_d = lap_cnt_q + 1'b1;
            end
        end else if (read && (lap_cnt_q > LCW'(1))) begin
            if (rd_ptr_q == oldest) begin
                rd_ptr_d = wr_ptr_q - 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lap_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lap_q[i] <= TIME_ZERO;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lap_cnt_q <= lap_cnt_d;
            if (write) begin
                lap_q[wr_ptr_q] <= time_q;
            end
        end
    end

    always_comb begin
        disp_time = time_q;
        if (output_select == SEL_LAP) begin
            disp_time = (lap_cnt_q == '0) ? TIME_ZERO : lap_q[rd_ptr_q];
        end
    end

    assign flag      = enable_decrement && time_is_zero(time_q);
    assign disp_min  = disp_time.min;
    assign disp_sec  = disp_time.sec;
    assign lap_count = lap_cnt_q;

endmodule

// File: tb/tb_time_datapath.sv
// Directed bench for time_datapath with a 4-cycle second and 4 lap slots.
module tb_time_datapath;
    import time_pkg::*;

    localparam logic [1:0] SEL_LIVE = 2'b00;

    logic       clk = 1'b0;
    logic       nrst;
    logic       clear;
    logic       enable;
    logic       enable_decrement;
    logic       enable_increment;
    logic       inc_pulse;
    logic       write;
    logic       read;
    logic [1:0] output_select;
    logic       flag;
    logic [6:0] disp_min;
    logic [5:0] disp_sec;
    logic [2:0] lap_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    time_datapath #(
        .TICKS_PER_SEC (4),
        .DEPTH         (4)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .clear            (clear),
        .enable           (enable),
        .enable_decrement (enable_decrement),
        .enable_increment (enable_increment),
        .inc_pulse        (inc_pulse),
        .write            (write),
        .read             (read),
        .output_select    (output_select),
        .flag             (flag),
        .disp_min         (disp_min),
        .disp_sec         (disp_sec),
        .lap_count        (lap_count)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int m, input int s);
        chk({tag, ".min"}, 32'(disp_min), 32'(m));
        chk({tag, ".sec"}, 32'(disp_sec), 32'(s));
    endtask

    initial begin
        int lap_gap [5] = '{20, 16, 12, 32, 44};
        int lap_sec [5] = '{5, 9, 12, 20, 31};
        int rd_exp  [4] = '{20, 12, 9, 31};

        nrst             = 1'b0;
        clear            = 1'b0;
        enable           = 1'b0;
        enable_decrement = 1'b0;
        enable_increment = 1'b0;
        inc_pulse        = 1'b0;
        write            = 1'b0;
        read             = 1'b0;
        output_select    = SEL_LIVE;
        #1;
        chk_disp("reset_disp", 0, 0);
        chk("reset_flag", 32'(flag), 0);
        chk("reset_lap_count", 32'(lap_count), 0);
        cyc(2);
        nrst = 1'b1;
        cyc(1);

        // Count up: first second exactly 4 cycles after enable.
        enable = 1'b1;
        cyc(3);
        chk_disp("up_before_first_tick", 0, 0);
        cyc(1);
        chk_disp("up_first_tick", 0, 1);
        cyc(240);
        chk_disp("up_244_cycles", 1, 1);
        cyc(23752);
        chk_disp("up_reach_max", 99, 59);
        chk("up_flag_low", 32'(flag), 0);
        cyc(32);
        chk_disp("up_saturate", 99, 59);

        enable_decrement = 1'b1;
        cyc(4);
        chk_disp("both_enables_decrement_wins", 99, 58);

        clear            = 1'b1;
        enable           = 1'b0;
        enable_decrement = 1'b0;
        cyc(1);
        clear = 1'b0;
        chk_disp("clear_time", 0, 0);

        inc_pulse = 1'b1;
        cyc(1);
        inc_pulse = 1'b0;
        chk_disp("inc_without_mode", 0, 0);

        enable_increment = 1'b1;
        repeat (3) begin
            inc_pulse = 1'b1;
            cyc(1);
            inc_pulse = 1'b0;
            cyc(1);
        end
        chk_disp("inc_three_minutes", 3, 0);

        // Countdown 03:00 -> 00:00; flag only on the final cycle.
        enable_increment = 1'b0;
        enable_decrement = 1'b1;
        for (int i = 1; i <= 720; i++) begin
            cyc(1);
            chk("countdown_flag", 32'(flag), 32'(i == 720));
            if (i == 360) chk_disp("countdown_mid", 1, 30);
        end
        chk_disp("countdown_zero", 0, 0);
        cyc(8);
        chk_disp("countdown_hold", 0, 0);
        chk("countdown_flag_hold", 32'(flag), 1);
        enable_decrement = 1'b0;
        #1;
        chk("flag_drops_without_countdown", 32'(flag), 0);
        enable_decrement = 1'b1;
        #1;
        chk("flag_immediate_at_zero", 32'(flag), 1);
        enable_decrement = 1'b0;
        cyc(1);

        // Lap memory.
        clear = 1'b1;
        cyc(1);
        clear         = 1'b0;
        output_select = SEL_LAP;
        read          = 1'b1;
        cyc(1);
        read = 1'b0;
        chk_disp("read_empty_view", 0, 0);
        chk("read_empty_count", 32'(lap_count), 0);
        for (int i = 0; i < 5; i++) begin
            output_select = SEL_LIVE;
            enable        = 1'b1;
            cyc(lap_gap[i]);
            enable = 1'b0;
            chk_disp("lap_live_time", 0, lap_sec[i]);
            if (i == 0) begin
                output_select = SEL_LAP;
                #1;
                chk_disp("lap_view_empty_nonzero_live", 0, 0);
            end
            write = 1'b1;
            cyc(1);
            write = 1'b0;
        end
        output_select = SEL_LAP;
        #1;
        chk("lap_count_saturated", 32'(lap_count), 4);
        chk_disp("lap_newest", 0, 31);
        for (int i = 0; i < 4; i++) begin
            read = 1'b1;
            cyc(1);
            read = 1'b0;
            chk_disp("lap_read_walk", 0, rd_exp[i]);
        end

        output_select = SEL_LIVE;
        enable        = 1'b1;
        cyc(4);
        enable = 1'b0;
        chk_disp("wr_rd_live", 0, 32);
        write = 1'b1;
        read  = 1'b1;
        cyc(1);
        write         = 1'b0;
        read          = 1'b0;
        output_select = SEL_LAP;
        #1;
        chk_disp("wr_rd_same_cycle_view", 0, 32);
        chk("wr_rd_same_cycle_count", 32'(lap_count), 4);
        read = 1'b1;
        cyc(1);
        read = 1'b0;
        chk_disp("wr_rd_then_read", 0, 31);

        // Clear coinciding with a tick and an increment strobe.
        output_select = SEL_LIVE;
        enable        = 1'b1;
        cyc(3);
        clear            = 1'b1;
        inc_pulse        = 1'b1;
        enable_increment = 1'b1;
        cyc(1);
        clear            = 1'b0;
        inc_pulse        = 1'b0;
        enable_increment = 1'b0;
        chk_disp("clear_wins", 0, 0);
        cyc(3);
        chk_disp("clear_prescaler_restart", 0, 0);
        cyc(1);
        chk_disp("clear_first_tick", 0, 1);
        enable        = 1'b0;
        output_select = SEL_LAP;
        #1;
        chk_disp("clear_keeps_laps", 0, 31);
        chk("clear_keeps_lap_count", 32'(lap_count), 4);

        // Asynchronous reset mid-countdown at 01:30.
        output_select = SEL_LIVE;
        clear         = 1'b1;
        cyc(1);
        clear            = 1'b0;
        enable_increment = 1'b1;
        inc_pulse        = 1'b1;
        cyc(1);
        inc_pulse        = 1'b0;
        enable_increment = 1'b0;
        enable           = 1'b1;
        cyc(120);
        enable = 1'b0;
        chk_disp("pre_reset_time", 1, 30);
        enable_decrement = 1'b1;
        cyc(2);
        chk_disp("pre_reset_countdown", 1, 30);
        nrst             = 1'b0;
        enable_decrement = 1'b0;
        #1;
        chk_disp("async_reset_disp", 0, 0);
        chk("async_reset_flag", 32'(flag), 0);
        chk("async_reset_lap_count", 32'(lap_count), 0);
        output_select = SEL_LAP;
        #1;
        chk_disp("async_reset_lap_view", 0, 0);
        output_select = SEL_LIVE;
        enable        = 1'b1;
        cyc(1);
        nrst = 1'b1;
        cyc(3);
        chk_disp("post_reset_no_early_tick", 0, 0);
        cyc(1);
        chk_disp("post_reset_first_tick", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_datapath.md
# time_datapath

Datapath responder to the stopwatch/timer control FSM. It consumes the FSM's one-hot-style control strobes (`clear`, `enable`, `read`, `write`, `enable_increment`, `enable_decrement`, `output_select`) and returns `flag` when a countdown reaches zero. It holds the live MM:SS time register, a second-tick prescaler and a small circular lap memory, and it drives the display value selected by `output_select`.

## Interface
- `TICKS_PER_SEC`, default 10_000_000: clock cycles per one-second tick; must be ≥ 2.
- `DEPTH`, default 4: number of lap entries; must be a power of two and ≥ 2.
- `clk` input 1: system clock, rising edge.
- `nrst` input 1: reset; one clock; reset is asynchronous and active-low.
- `clear` input 1: zero the live time and the prescaler.
- `enable` input 1: count up (stopwatch).
- `enable_decrement` input 1: count down (timer).
- `enable_increment` input 1: timer-set mode; gates `inc_pulse`.
- `inc_pulse` input 1: single-cycle strobe from the button conditioner; adds one minute while `enable_increment` is high.
- `write` input 1: store the live time as a new lap.
- `read` input 1: step the lap read pointer to the next older entry.
- `output_select` input 2: display source; `2'b10` shows the lap at the read pointer; every other code shows the live time.
- `flag` output 1: countdown at zero; high while `enable_decrement` is high and the live time is 00:00.
- `disp_min` output 7: displayed minutes, 0–99.
- `disp_sec` output 6: displayed seconds, 0–59.
- `lap_count` output clog2(DEPTH+1): number of valid laps, saturating at DEPTH.

## Operation
- Live time is `{min, sec}`, with min 0–99 and sec 0–59. It is never binary-wrapped.
- Priority per cycle, highest first: `clear`, `inc_pulse`&`enable_increment`, tick with `enable_decrement`, tick with `enable`.
- If both `enable` and `enable_decrement` are high, decrement wins. The FSM never does this; the bench checks it anyway.
- Tick is internal: it is high for one cycle when the prescaler equals `TICKS_PER_SEC-1`.
  - The prescaler runs only while `enable` or `enable_decrement` is high.
  - It is forced to 0 on `clear`, and whenever neither enable is high.
- Up-count: sec 59→0 with min+1. At 99:59 the time holds (saturates).
- Down-count: sec 0→59 with min−1. At 00:00 the time holds.
- Increment: min+1, saturating at 99; sec is unchanged.
- `flag` is combinational from the registered time and `enable_decrement`. It never fires while not in countdown.
- Lap write:
  - The lap memory stores the live time as it was before this cycle's update.
  - The write pointer advances modulo DEPTH.
  - The read pointer is set to the newly written slot.
  - `lap_count` increments, saturating at DEPTH; once full, the oldest entry is overwritten.
- Lap read:
  - The read pointer steps to the previous slot.
  - Reaching the oldest valid entry wraps to the newest. The oldest is slot wr_ptr when full, else slot 0.
  - With `lap_count`==0, `read` is a no-op.
  - With `lap_count`==1, the pointer stays put.
- `write` and `read` in the same cycle: `write` wins and `read` is ignored.
- `clear` does not touch the lap memory, lap pointers or `lap_count`. The FSM holds `clear` high for the whole of mode select.
- Display with `output_select`==2'b10 and `lap_count`==0 is 00:00.

## Timing
- Reset values:
  - time 00:00, prescaler 0, pointers 0, `lap_count` 0.
  - Lap memory all 00:00.
  - Outputs: `flag` 0, `disp_min` 0, `disp_sec` 0, `lap_count` 0.
- All state updates occur on the rising `clk` edge after the qualifying input is sampled. The visible effect appears the next cycle.
- From `enable` rising, the first sec increment lands TICKS_PER_SEC cycles later.
- `flag` rises in the same cycle the registered time becomes 00:00 under `enable_decrement`. If a countdown is entered at 00:00, `flag` is high immediately (zero-latency, combinational).
- Display outputs are combinational from registered state. Lap memory reads are asynchronous, so a selected lap appears in the same cycle as the `output_select` change.
- Reset asserted mid-count or mid-write returns everything to reset values immediately. The first tick after release is a full TICKS_PER_SEC away.

## Structure
- Package `time_pkg` holds:
  - `time_t` packed struct `{logic [6:0] min; logic [5:0] sec;}`.
  - Constants `MAX_MIN`=99 and `MAX_SEC`=59.
  - Display-select localparam `SEL_LAP`=2'b10.
- Sub-module `tick_gen` contains the prescaler. Its inputs are `clk`, `nrst`, `run` and `sync_clr`; its output is a one-cycle `tick`.
- The lap memory is an array of `time_t` inside `time_datapath`; it needs no separate module.

## Test plan
- Reset then `enable` with TICKS_PER_SEC=4 for 244 cycles → display 01:01. Continue to 99:59 and hold 8 more ticks → still 99:59.
- `enable_increment` with 3 `inc_pulse` strobes → 03:00. Then `enable_decrement` for 180 ticks → 00:00 with `flag`=1 on that exact cycle. `flag` stays 0 for every earlier cycle.
- With live times 00:05, 00:09, 00:12, 00:20, 00:31 (DEPTH=4):
  - Write each of the five → `lap_count`=4; lap view shows 00:31.
  - Then 4 `read` pulses → 00:20, 00:12, 00:09, 00:31 (wrap; 00:05 overwritten).
- `read` with `lap_count`=0 → lap view 00:00, no pointer change.
- `write` and `read` in the same cycle → lap stored, pointer on the new slot.
- `clear` asserted together with a tick and with `inc_pulse` → time 00:00, prescaler restarts. Laps and `lap_count` are unchanged.
- `nrst` pulsed low mid-countdown at 01:30 → all outputs 0 asynchronously, before the next clock edge. After release, no tick for TICKS_PER_SEC cycles.
